// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq
// Brief   : Registered 15-op ALU plus iterative unsigned MUL/DIV, START/BUSY/DONE.
// Rev     : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             c,
    output logic             z,
    output logic             div0
);
    localparam logic [4:0] OP_MUL = 5'h10;
    localparam logic [4:0] OP_DIV = 5'h11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ITER = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // hi/lo: product or remainder/quotient while iterating, then the pending result
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             pc_q, pc_d, pz_q, pz_d, pd_q, pd_d;
    logic [WIDTH-1:0] res_q, res_d, rhi_q, rhi_d;
    logic             c_q, c_d, z_q, z_d, div0_q, div0_d, done_q, done_d;

    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] op_res, op_hi;
    logic             op_c, op_z, op_div0;
    logic [WIDTH:0]   sum, sh;

    // ext is {C,RESULT} for the single-cycle set
    always_comb begin
        ext     = '0;
        op_hi   = '0;
        op_z    = 1'b0;
        op_div0 = 1'b0;
        case (sel_q)
            5'h00:        ext = {1'b0, a_q} + {1'b0, b_q};
            5'h01:        ext = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
            5'h02, 5'h04: ext = {1'b0, a_q} - {1'b0, b_q};
            5'h03:        ext = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
            5'h05, 5'h08: ext = {1'b0, a_q & b_q};
            5'h06:        ext = {1'b0, a_q | b_q};
            5'h07:        ext = {1'b0, a_q ^ b_q};
            5'h09:        ext = {a_q, cin_q};
            5'h0A:        ext = {a_q[0], cin_q, a_q[WIDTH-1:1]};
            5'h0B:        ext = {a_q[WIDTH-1], a_q[WIDTH-2:0], a_q[WIDTH-1]};
            5'h0C:        ext = {a_q[0], a_q[0], a_q[WIDTH-1:1]};
            5'h0D:        ext = {a_q[0], a_q[WIDTH-1], a_q[WIDTH-1:1]};
            5'h0E:        ext = {1'b0, b_q};
            OP_MUL:       op_z = 1'b1;
            OP_DIV: begin
                ext     = {1'b1, {WIDTH{1'b1}}};
                op_hi   = a_q;
                op_div0 = 1'b1;
            end
            default:      ext = '0;
        endcase
        op_res = ext[WIDTH-1:0];
        op_c   = ext[WIDTH];
        if (sel_q <= 5'h0D) begin
            op_z = (ext == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pc_d    = pc_q;
        pz_d    = pz_q;
        pd_d    = pd_q;
        res_d   = res_q;
        rhi_d   = rhi_q;
        c_d     = c_q;
        z_d     = z_q;
        div0_d  = div0_q;
        done_d  = 1'b0;
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        sh      = {hi_q, lo_q[WIDTH-1]};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = sel;
                    a_d     = a;
                    b_d     = b;
                    cin_d   = cin;
                    cnt_d   = CNT_W'(WIDTH);
                    hi_d    = '0;
                    lo_d    = (sel == OP_MUL) ? b : a;
                    state_d = ((sel == OP_MUL || sel == OP_DIV) && b != '0) ? S_ITER : S_EXEC;
                end
            end
            S_EXEC: begin
                hi_d    = op_hi;
                lo_d    = op_res;
                pc_d    = op_c;
                pz_d    = op_z;
                pd_d    = op_div0;
                state_d = S_FIN;
            end
            S_ITER: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (sel_q == OP_MUL) begin
                        hi_d = sum[WIDTH:1];
                        lo_d = {sum[0], lo_q[WIDTH-1:1]};
                    end else if (sh >= {1'b0, b_q}) begin
                        // remainder < B before the shift, so the difference fits WIDTH bits
                        hi_d = sh[WIDTH-1:0] - b_q;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = sh[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    pc_d    = (sel_q == OP_MUL) && (hi_q != '0);
                    pz_d    = (sel_q == OP_MUL) ? ({hi_q, lo_q} == '0) : (lo_q == '0);
                    pd_d    = 1'b0;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                res_d   = lo_q;
                rhi_d   = hi_q;
                c_d     = pc_q;
                z_d     = pz_q;
                div0_d  = pd_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pc_q    <= 1'b0;
            pz_q    <= 1'b0;
            pd_q    <= 1'b0;
            res_q   <= '0;
            rhi_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pc_q    <= pc_d;
            pz_q    <= pz_d;
            pd_q    <= pd_d;
            res_q   <= res_d;
            rhi_q   <= rhi_d;
            c_q     <= c_d;
            z_q     <= z_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = res_q;
    assign result_hi = rhi_q;
    assign c         = c_q;
    assign z         = z_q;
    assign div0      = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_seq
// Brief   : Random + directed bench for alu_seq against a cycle-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_seq;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] h;
        logic       c;
        logic       z;
        logic       d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [4:0] sel = '0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       busy, done, c, z, div0;
    logic [7:0] result, result_hi;

    logic        s_start = 1'b0;
    logic [4:0]  s_sel = '0;
    logic [15:0] s_a = '0, s_b = '0;
    logic        s_cin = 1'b0;
    logic        s_busy, s_done, s_c, s_z, s_div0;
    logic [15:0] s_res, s_hi;

    int total = 0;
    int bad   = 0;

    exp_t m = '0, p = '0;
    logic m_done = 1'b0;
    int   m_left = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi),
        .c(c), .z(z), .div0(div0)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .sel(s_sel), .a(s_a), .b(s_b), .cin(s_cin),
        .busy(s_busy), .done(s_done), .result(s_res), .result_hi(s_hi),
        .c(s_c), .z(s_z), .div0(s_div0)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference: the op table written as plain integer arithmetic
    function automatic exp_t model_f(input logic [4:0] s, input logic [7:0] x, input logic [7:0] y,
                                     input logic ci);
        exp_t e;
        int   t;
        int   pr;
        e = '0;
        t = 0;
        case (s)
            5'h00: t = int'(x) + int'(y);
            5'h01: t = int'(x) + int'(y) + int'(ci);
            5'h02, 5'h04: t = int'(x) - int'(y);
            5'h03: t = int'(x) - int'(y) - int'(ci);
            5'h05, 5'h08: t = int'(x & y);
            5'h06: t = int'(x | y);
            5'h07: t = int'(x ^ y);
            5'h09: t = int'(x) * 2 + int'(ci);
            5'h0A: t = int'(ci) * 128 + int'(x) / 2 + (x[0] ? 256 : 0);
            5'h0B: t = (int'(x) * 2) % 256 + int'(x) / 128 + (x[7] ? 256 : 0);
            5'h0C: t = int'(x) / 2 + (x[0] ? 128 + 256 : 0);
            5'h0D: t = int'(x) / 2 + int'(x & 8'h80) + (x[0] ? 256 : 0);
            default: t = 0;
        endcase
        if (s <= 5'h0D) begin
            e.c = (t < 0) || (t >= 256);
            if (t < 0) t = t + 256;
            e.r = 8'(t % 256);
            e.z = (e.r == 8'h00) && !e.c;
        end else if (s == 5'h0E) begin
            e.r = y;
        end else if (s == 5'h10) begin
            pr  = int'(x) * int'(y);
            e.r = 8'(pr % 256);
            e.h = 8'(pr / 256);
            e.c = (e.h != 8'h00);
            e.z = (pr == 0);
        end else if (s == 5'h11) begin
            if (y == 8'h00) begin
                e.r = 8'hFF;
                e.h = x;
                e.c = 1'b1;
                e.d = 1'b1;
            end else begin
                e.r = x / y;
                e.h = x % y;
                e.z = (e.r == 8'h00);
            end
        end
        return e;
    endfunction

    function automatic int lat_of(input logic [4:0] s, input logic [7:0] y);
        return ((s == 5'h10 || s == 5'h11) && y != 8'h00) ? 10 : 2;
    endfunction

    // Model timeline: accept when idle, count latency down, publish at zero
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m      <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m      <= p;
                end
            end else if (start) begin
                p      <= model_f(sel, a, b, cin);
                m_left <= lat_of(sel, b);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_left != 0});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("result", {24'd0, result}, {24'd0, m.r});
        chk("result_hi", {24'd0, result_hi}, {24'd0, m.h});
        chk("c", {31'd0, c}, {31'd0, m.c});
        chk("z", {31'd0, z}, {31'd0, m.z});
        chk("div0", {31'd0, div0}, {31'd0, m.d});
    end

    task automatic run_op(input string nm, input logic [4:0] s, input logic [7:0] x, input logic [7:0] y,
                          input logic ci, input logic [7:0] er, input logic [7:0] eh,
                          input logic ec, input logic ez, input logic ed, input int elat);
        int n;
        @(negedge clk);
        sel = s; a = x; b = y; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n - 1, elat);
        chk({nm, " result"}, {24'd0, result}, {24'd0, er});
        chk({nm, " result_hi"}, {24'd0, result_hi}, {24'd0, eh});
        chk({nm, " c"}, {31'd0, c}, {31'd0, ec});
        chk({nm, " z"}, {31'd0, z}, {31'd0, ez});
        chk({nm, " div0"}, {31'd0, div0}, {31'd0, ed});
        chk({nm, " model"}, {16'd0, m.r, m.h}, {16'd0, er, eh});
        chk({nm, " model flags"}, {29'd0, m.c, m.z, m.d}, {29'd0, ec, ez, ed});
    endtask

    task automatic run16(input string nm, input logic [4:0] s, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] er, input logic [15:0] eh, input logic ec, input int elat);
        int n;
        @(negedge clk);
        s_sel = s; s_a = x; s_b = y; s_cin = 1'b0; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk({nm, " busy"}, {31'd0, s_busy}, 32'd1);
        n = 1;
        while (s_done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n - 1, elat);
        chk({nm, " result"}, {s_hi, s_res}, {eh, er});
        chk({nm, " flags"}, {29'd0, s_c, s_z, s_div0}, {29'd0, ec, 2'b00});
    endtask

    initial begin
        int n;
        int r;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {13'd0, busy, done, result, result_hi, c, z, div0},
            32'd0);
        rst_n = 1'b1;

        run_op("T1 ADD", 5'h00, 8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2);
        run_op("T1 SUB", 5'h02, 8'h05, 8'h05, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2);
        run_op("T2 SUBC", 5'h03, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 2);
        run_op("T2 LSR", 5'h0A, 8'h01, 8'h00, 1'b1, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 2);
        run_op("LSL", 5'h09, 8'h81, 8'h00, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 2);
        run_op("MOV", 5'h0E, 8'h12, 8'h5A, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 2);
        run_op("T3 MUL", 5'h10, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 10);
        run_op("T3 MUL0", 5'h10, 8'h00, 8'h37, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 10);
        run_op("T4 DIV", 5'h11, 8'h64, 8'h07, 1'b0, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 10);
        run_op("T4 DIV0", 5'h11, 8'h2A, 8'h00, 1'b0, 8'hFF, 8'h2A, 1'b1, 1'b0, 1'b1, 2);
        run_op("UNDEF", 5'h0F, 8'h33, 8'h44, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2);

        // T5: START held, operands changed mid-op
        @(negedge clk);
        sel = 5'h10; a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                sel = 5'h00; a = 8'h01; b = 8'h02;
            end
        end
        chk("T5 latency", n - 1, 10);
        chk("T5 product", {16'd0, result_hi, result}, 32'h0000FE01);
        @(negedge clk);
        chk("T5 next accept", {30'd0, busy, done}, 32'd2);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("T5 second result", {24'd0, result}, 32'h03);

        // T6: reset during MUL iteration 4
        @(negedge clk);
        sel = 5'h10; a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("T6 reset outputs", {13'd0, busy, done, result, result_hi, c, z, div0}, 32'd0);
        repeat (2) @(negedge clk);
        chk("T6 no done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        run_op("T6 ADD", 5'h00, 8'h01, 8'h01, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 2);

        // Random traffic including ignored STARTs and one asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            r = int'($urandom_range(0, 7));
            sel = (r < 3) ? 5'h10 + 5'($urandom_range(0, 1)) : 5'($urandom_range(0, 31));
            a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            cin = 1'($urandom);
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (15) @(negedge clk);

        run16("W16 ADD", 5'h00, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 2);
        run16("W16 MUL", 5'h10, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
